cmd_tlm_bridge: RTL
===================

Name: cmd_tlm_bridge

Overview:
- Bridge between the UART byte interfaces and the actuator/telemetry paths; generalises the current top-level RX/TX glue logic.
- RX side: parses command bytes into one motor direction and NUM_SERVO servo angles, with relative and absolute modes.
- TX side: synchronises strobes from two telemetry sources (camera init, camera frame), buffers bytes in a FIFO and drives the UART_TX start/finish handshake.
- Sits in the sys_clk domain, between UART_RX/UART_TX and the SERVO/MOTOR/OV_* blocks.

Parameters:
NUM_SERVO, 2, number of servo channels (1..64)
ANGLE_W, 8, angle width in bits
ANGLE_MIN, 195, lower clamp for every angle
ANGLE_MAX, 255, upper clamp for every angle
ANGLE_DEF, 225, reset/straight angle
STEP, 1, increment for relative turn commands
FIFO_DEPTH, 16, TX FIFO depth; power of 2, at least 2
SYNC_STAGES, 2, synchroniser flops ahead of the edge-detect flop

Ports:
sys_clk  in  1  system clock
rst  in  1  synchronous reset, active-high
rx_finish  in  1  UART_RX byte-done level (slow domain); a rising edge means a new byte
rx_data  in  8  UART_RX byte; stable while rx_finish is high
tlm_sel  in  1  telemetry source select: 0 = init source, 1 = frame source
init_strobe  in  1  init source byte-valid level (slow domain)
init_data  in  8  init source byte
frame_strobe  in  1  frame source byte-valid level (slow domain)
frame_data  in  8  frame source byte
tx_finish  in  1  UART_TX idle flag (slow domain); high when idle
tx_start  out  1  UART_TX start request
tx_data  out  8  UART_TX byte
angle  out  NUM_SERVO*ANGLE_W  packed servo angles; channel 0 in the LSBs
direction  out  2  motor direction: 11 forward, 00 backward, 01 halt
cmd_err  out  1  one-cycle pulse on an illegal command
fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
drop_cnt  out  16  count of telemetry bytes dropped on a full FIFO; saturates at 0xFFFF

Behaviour:
Reset values:
- Every angle = ANGLE_DEF; direction = 01; tx_start = 0; tx_data = 0; cmd_err = 0.
- FIFO empty; drop_cnt = 0; parser in P_IDLE; TX FSM in T_IDLE; all synchroniser flops cleared.

Synchronisation:
- rx_finish, init_strobe, frame_strobe and tx_finish each pass through SYNC_STAGES flops, plus one history flop for edge detection.
- Rising-edge event is valid SYNC_STAGES+1 cycles after the input rises.

Parser states: P_IDLE, P_ABS(ch). On an rx event in P_IDLE, decode rx_data[1:0]:
- 00 (legacy, channel 0):
  - [7:5]: 011 sets direction 11; 110 sets direction 00; anything else sets direction 01.
  - [4:2]: 011 adds STEP only if angle0+STEP <= ANGLE_MAX, otherwise no change; 110 subtracts STEP only if angle0-STEP >= ANGLE_MIN, otherwise no change; 101 sets ANGLE_DEF; anything else leaves the angle unchanged.
  - Comparisons use ANGLE_W+1 bits, so there is no wrap.
- 01 (absolute header): ch = rx_data[7:2].
  - ch < NUM_SERVO: go to P_ABS(ch).
  - Otherwise: pulse cmd_err and stay in P_IDLE.
- 10: all angles = ANGLE_DEF and direction = 01, in one cycle.
- 11: pulse cmd_err; no state change.
- P_ABS(ch): the next rx event writes rx_data to angle[ch], clamped to [ANGLE_MIN, ANGLE_MAX]; return to P_IDLE. Absolute-mode bytes are never decoded as opcodes.
- Outputs update in the cycle after the event is detected.

Telemetry push:
- The synchronisers for both sources always run.
- Only the source selected by tlm_sel in the event cycle pushes its data byte; the other source's events are discarded.
- A push is accepted if fifo_level < FIFO_DEPTH, or if a pop occurs in the same cycle.
- Otherwise the byte is dropped and drop_cnt increments, saturating at 0xFFFF.

TX FSM states: T_IDLE, T_ACK, T_DONE.
- T_IDLE: when the FIFO is not empty and synced tx_finish = 1, pop the head into tx_data, set tx_start = 1, go to T_ACK.
- T_ACK: hold tx_start and tx_data until synced tx_finish = 0; then clear tx_start and go to T_DONE.
- T_DONE: wait for synced tx_finish = 1, then go to T_IDLE.
- At most one byte is in flight. tx_data is stable from tx_start assertion until the next pop.
- FIFO order is strictly first-in, first-out; pointers wrap modulo FIFO_DEPTH.

Reset mid-operation:
- rst at any cycle returns everything to the reset values above, including a partial P_ABS sequence and an in-flight tx_start.

Decomposition:
- Shared package bridge_pkg holds:
  - opcode constants OP_LEGACY = 2'b00, OP_ABS = 2'b01, OP_HOME = 2'b10, OP_RSVD = 2'b11;
  - direction encodings DIR_FWD = 2'b11, DIR_BWD = 2'b00, DIR_HALT = 2'b01;
  - legacy sub-codes 3'b011, 3'b110, 3'b101.
- One sub-module: sync_fifo (parameters WIDTH and DEPTH; push/pop/full/empty/level), instantiated once for the TX buffer.

Test Plan:
- Reset, then rx byte 0x6C (legacy, motor 011, servo 011) -> direction = 11, angle0 = 226 exactly SYNC_STAGES+2 cycles after the rx_finish rise.
- Apply 35 consecutive 0x0C bytes from reset -> angle0 saturates at 255; 0x18 -> 254; 0x14 -> 225.
- Bytes 0x05 then 0x10 -> angle1 = 195 (clamped); bytes 0x09 (ch2, NUM_SERVO = 2) -> cmd_err pulse, parser stays in P_IDLE, next byte 0x0C decoded as legacy -> angle0 = 226.
- tlm_sel = 1, tx_finish held low, 20 frame strobes carrying 0x00..0x13 -> fifo_level = 16, drop_cnt = 4; init strobes ignored.
- Release tx_finish with a model that drops finish on start and re-raises it 10 cycles later -> tx_data sequence 0x00..0x0F in order, exactly one tx_start per byte.
- Assert rst while in P_ABS and in T_ACK -> tx_start = 0, all angles = 225, direction = 01, FIFO empty; a following 0x10 is treated as legacy and leaves angle0 = 225.

Source files
------------

// File: rtl/bridge_pkg.sv
// -----------------------------------------------------------------------------
// bridge_pkg
// Shared definitions for the command/telemetry bridge: command opcodes, motor
// direction encodings, legacy sub-codes, FSM state types and the debug view
// struct that exposes every FSM state of cmd_tlm_bridge.
// -----------------------------------------------------------------------------
package bridge_pkg;

  // Command opcode, carried in rx byte bits [1:0].
  localparam logic [1:0] OP_LEGACY = 2'b00;
  localparam logic [1:0] OP_ABS    = 2'b01;
  localparam logic [1:0] OP_HOME   = 2'b10;
  localparam logic [1:0] OP_RSVD   = 2'b11;

  // Motor direction encodings.
  localparam logic [1:0] DIR_FWD  = 2'b11;
  localparam logic [1:0] DIR_BWD  = 2'b00;
  localparam logic [1:0] DIR_HALT = 2'b01;

  // Legacy sub-codes. The same three codes are used for the motor field
  // [7:5] (forward / backward) and the servo field [4:2] (up / down / home).
  localparam logic [2:0] SUB_UP   = 3'b011;
  localparam logic [2:0] SUB_DOWN = 3'b110;
  localparam logic [2:0] SUB_DEF  = 3'b101;

  // Width of the channel field of an absolute header (rx byte bits [7:2]).
  localparam int CH_W = 6;

  typedef enum logic {
    P_IDLE = 1'b0,
    P_ABS  = 1'b1
  } p_state_e;

  typedef enum logic [1:0] {
    T_IDLE = 2'b00,
    T_ACK  = 2'b01,
    T_DONE = 2'b10
  } t_state_e;

  // Snapshot of all bridge FSM state, brought out for checkers.
  typedef struct packed {
    p_state_e          p_state;
    logic [CH_W-1:0]   abs_ch;
    t_state_e          t_state;
  } bridge_dbg_t;

  // Motor field [7:5] of a legacy command to a direction encoding.
  function automatic logic [1:0] motor_dir(input logic [2:0] code);
    logic [1:0] dir;
    case (code)
      SUB_UP:   dir = DIR_FWD;
      SUB_DOWN: dir = DIR_BWD;
      default:  dir = DIR_HALT;
    endcase
    return dir;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock first-in first-out buffer with a registered occupancy count.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
// A pop on an empty FIFO is ignored. rdata shows the head entry whenever the
// FIFO is not empty.
//
// Ports:
//   clk    in   clock
//   rst    in   synchronous active-high reset (empties the FIFO)
//   push   in   write request, wdata is stored when accepted
//   wdata  in   WIDTH-bit write data
//   pop    in   read request, removes the head entry
//   rdata  out  WIDTH-bit head entry
//   full   out  level == DEPTH
//   empty  out  level == 0
//   level  out  current occupancy, $clog2(DEPTH)+1 bits
// -----------------------------------------------------------------------------
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q,  level_d;
  logic             do_push, do_pop;

  assign full  = (level_q == LW'(DEPTH));
  assign empty = (level_q == '0);
  assign level = level_q;
  assign rdata = mem_q[rd_ptr_q];

  // Pointers are AW bits wide and DEPTH is a power of two, so they wrap
  // modulo DEPTH on their own.
  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/cmd_tlm_bridge.sv
// -----------------------------------------------------------------------------
// cmd_tlm_bridge
// Glue between the UART byte interfaces and the actuator / telemetry paths,
// all in the sys_clk domain.
//   RX: rx bytes are parsed into a motor direction and NUM_SERVO servo
//       angles (legacy relative commands, absolute header + value pairs,
//       home, reserved).
//   TX: byte strobes from the init or frame camera source are synchronised,
//       buffered in a FIFO and handed to UART_TX one at a time.
//
// Ports:
//   sys_clk       in   system clock
//   rst           in   synchronous active-high reset
//   rx_finish     in   UART_RX byte-done level (slow domain), rising = new byte
//   rx_data       in   UART_RX byte, stable while rx_finish is high
//   tlm_sel       in   telemetry source select: 0 init, 1 frame
//   init_strobe   in   init source byte-valid level (slow domain)
//   init_data     in   init source byte
//   frame_strobe  in   frame source byte-valid level (slow domain)
//   frame_data    in   frame source byte
//   tx_finish     in   UART_TX idle flag (slow domain), high when idle
//   tx_start      out  UART_TX start request
//   tx_data       out  UART_TX byte
//   angle         out  packed servo angles, channel 0 in the LSBs
//   direction     out  motor direction: 11 forward, 00 backward, 01 halt
//   cmd_err       out  one-cycle pulse on an illegal command
//   fifo_level    out  TX FIFO occupancy
//   drop_cnt      out  telemetry bytes dropped on a full FIFO, saturating
//   dbg_state     out  parser / TX FSM state snapshot
//
// UART_TX handshake: tx_start is a request that stays high, with tx_data
// frozen, until the synchronised tx_finish is seen low (UART busy = the
// byte was taken). The bridge then waits for tx_finish to return high
// before it may pop and request the next byte, so at most one byte is in
// flight and tx_data only changes on a pop.
// -----------------------------------------------------------------------------
module cmd_tlm_bridge
  import bridge_pkg::*;
#(
  parameter int NUM_SERVO   = 2,
  parameter int ANGLE_W     = 8,
  parameter int ANGLE_MIN   = 195,
  parameter int ANGLE_MAX   = 255,
  parameter int ANGLE_DEF   = 225,
  parameter int STEP        = 1,
  parameter int FIFO_DEPTH  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                           sys_clk,
  input  logic                           rst,
  input  logic                           rx_finish,
  input  logic [7:0]                     rx_data,
  input  logic                           tlm_sel,
  input  logic                           init_strobe,
  input  logic [7:0]                     init_data,
  input  logic                           frame_strobe,
  input  logic [7:0]                     frame_data,
  input  logic                           tx_finish,
  output logic                           tx_start,
  output logic [7:0]                     tx_data,
  output logic [NUM_SERVO*ANGLE_W-1:0]   angle,
  output logic [1:0]                     direction,
  output logic                           cmd_err,
  output logic [$clog2(FIFO_DEPTH):0]    fifo_level,
  output logic [15:0]                    drop_cnt,
  output bridge_dbg_t                    dbg_state
);

  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
  localparam int AW1   = ANGLE_W + 1;

  // Bit positions inside the synchroniser bundle.
  localparam int S_RX    = 0;
  localparam int S_INIT  = 1;
  localparam int S_FRAME = 2;
  localparam int S_TXF   = 3;

  // ---------------------------------------------------------------------------
  // Synchronisers and edge detection
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0][3:0] sync_q, sync_d;
  logic [2:0]                  hist_q, hist_d;
  logic [2:0]                  evt_q,  evt_d;
  logic                        txf_sync;

  // The rising-edge event is registered, so it is valid SYNC_STAGES+1 cycles
  // after the input rises and the parser / FIFO act one cycle later.
  always_comb begin
    sync_d[0] = {tx_finish, frame_strobe, init_strobe, rx_finish};
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
    hist_d = sync_q[SYNC_STAGES-1][2:0];
    evt_d  = sync_q[SYNC_STAGES-1][2:0] & ~hist_q;
  end

  assign txf_sync = sync_q[SYNC_STAGES-1][S_TXF];

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      sync_q <= '0;
      hist_q <= '0;
      evt_q  <= '0;
    end else begin
      sync_q <= sync_d;
      hist_q <= hist_d;
      evt_q  <= evt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Command parser
  // ---------------------------------------------------------------------------
  p_state_e              p_state_q, p_state_d;
  logic [CH_W-1:0]       abs_ch_q,  abs_ch_d;
  logic [ANGLE_W-1:0]    angle_q [NUM_SERVO];
  logic [ANGLE_W-1:0]    angle_d [NUM_SERVO];
  logic [1:0]            dir_q, dir_d;
  logic                  cmd_err_q, cmd_err_d;
  logic [AW1-1:0]        a0_ext, a0_up;
  logic                  rx_ev;

  function automatic logic [ANGLE_W-1:0] clamp_angle(input logic [7:0] v);
    logic [ANGLE_W-1:0] r;
    if (int'(v) < ANGLE_MIN)      r = ANGLE_W'(ANGLE_MIN);
    else if (int'(v) > ANGLE_MAX) r = ANGLE_W'(ANGLE_MAX);
    else                          r = ANGLE_W'(v);
    return r;
  endfunction

  assign rx_ev = evt_q[S_RX];

  // Relative steps are checked one bit wider than the angle so a step past
  // either limit is refused instead of wrapping.
  assign a0_ext = {1'b0, angle_q[0]};
  assign a0_up  = a0_ext + AW1'(STEP);

  always_comb begin
    p_state_d = p_state_q;
    abs_ch_d  = abs_ch_q;
    angle_d   = angle_q;
    dir_d     = dir_q;
    cmd_err_d = 1'b0;
    if (rx_ev) begin
      if (p_state_q == P_ABS) begin
        // Value byte of an absolute pair: never decoded as an opcode.
        for (int i = 0; i < NUM_SERVO; i++) begin
          if (abs_ch_q == CH_W'(i)) angle_d[i] = clamp_angle(rx_data);
        end
        p_state_d = P_IDLE;
      end else begin
        case (rx_data[1:0])
          OP_LEGACY: begin
            dir_d = motor_dir(rx_data[7:5]);
            case (rx_data[4:2])
              SUB_UP: begin
                if (a0_up <= AW1'(ANGLE_MAX)) angle_d[0] = a0_up[ANGLE_W-1:0];
              end
              SUB_DOWN: begin
                if (a0_ext >= AW1'(ANGLE_MIN + STEP)) angle_d[0] = angle_q[0] - ANGLE_W'(STEP);
              end
              SUB_DEF: angle_d[0] = ANGLE_W'(ANGLE_DEF);
              default: angle_d[0] = angle_q[0];
            endcase
          end
          OP_ABS: begin
            if (int'(rx_data[7:2]) < NUM_SERVO) begin
              p_state_d = P_ABS;
              abs_ch_d  = rx_data[7:2];
            end else begin
              cmd_err_d = 1'b1;
            end
          end
          OP_HOME: begin
            for (int i = 0; i < NUM_SERVO; i++) angle_d[i] = ANGLE_W'(ANGLE_DEF);
            dir_d = DIR_HALT;
          end
          default: cmd_err_d = 1'b1;
        endcase
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      p_state_q <= P_IDLE;
      abs_ch_q  <= '0;
      dir_q     <= DIR_HALT;
      cmd_err_q <= 1'b0;
      for (int i = 0; i < NUM_SERVO; i++) angle_q[i] <= ANGLE_W'(ANGLE_DEF);
    end else begin
      p_state_q <= p_state_d;
      abs_ch_q  <= abs_ch_d;
      dir_q     <= dir_d;
      cmd_err_q <= cmd_err_d;
      angle_q   <= angle_d;
    end
  end

  for (genvar g = 0; g < NUM_SERVO; g++) begin : g_angle_out
    assign angle[g*ANGLE_W +: ANGLE_W] = angle_q[g];
  end

  assign direction = dir_q;
  assign cmd_err   = cmd_err_q;

  // ---------------------------------------------------------------------------
  // Telemetry push and TX FIFO
  // ---------------------------------------------------------------------------
  logic              push_req;
  logic [7:0]        push_byte;
  logic              fifo_pop;
  logic [7:0]        fifo_rdata;
  logic              fifo_full, fifo_empty;
  logic [LVL_W-1:0]  fifo_lvl;
  logic [15:0]       drop_q, drop_d;

  // Both sources are always synchronised; only the selected one may push.
  assign push_req  = tlm_sel ? evt_q[S_FRAME] : evt_q[S_INIT];
  assign push_byte = tlm_sel ? frame_data : init_data;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk   (sys_clk),
    .rst   (rst),
    .push  (push_req),
    .wdata (push_byte),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_lvl)
  );

  // A push into a full FIFO still lands if the TX side pops that cycle.
  always_comb begin
    drop_d = drop_q;
    if (push_req && fifo_full && !fifo_pop && (drop_q != 16'hFFFF)) begin
      drop_d = drop_q + 16'd1;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (rst) drop_q <= '0;
    else     drop_q <= drop_d;
  end

  assign fifo_level = fifo_lvl;
  assign drop_cnt   = drop_q;

  // ---------------------------------------------------------------------------
  // UART_TX handshake FSM
  // ---------------------------------------------------------------------------
  t_state_e    t_state_q, t_state_d;
  logic        tx_start_q, tx_start_d;
  logic [7:0]  tx_data_q,  tx_data_d;

  always_comb begin
    t_state_d  = t_state_q;
    tx_start_d = tx_start_q;
    tx_data_d  = tx_data_q;
    fifo_pop   = 1'b0;
    case (t_state_q)
      T_IDLE: begin
        if (!fifo_empty && txf_sync) begin
          fifo_pop   = 1'b1;
          tx_data_d  = fifo_rdata;
          tx_start_d = 1'b1;
          t_state_d  = T_ACK;
        end
      end
      T_ACK: begin
        if (!txf_sync) begin
          tx_start_d = 1'b0;
          t_state_d  = T_DONE;
        end
      end
      T_DONE: begin
        if (txf_sync) t_state_d = T_IDLE;
      end
      default: t_state_d = T_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      t_state_q  <= T_IDLE;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
    end else begin
      t_state_q  <= t_state_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
    end
  end

  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;

  assign dbg_state = '{p_state: p_state_q, abs_ch: abs_ch_q, t_state: t_state_q};

endmodule
